// File: rtl/ahb_bus_pkg.sv
// Shared system-bus definitions: HTRANS encodings and index-width helpers.
package ahb_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Binary index width for an n-entry one-hot vector (never below 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // NONSEQ or SEQ write; IDLE and BUSY never open a data phase.
  function automatic logic is_write_req(input logic [1:0] htrans, input logic hwrite);
    return hwrite && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  endfunction

endpackage

// File: rtl/ahb_wdata_mux_n_if.sv
// Bundle of address-phase controls, master write data and mux outputs.
interface ahb_wdata_mux_n_if #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16
);

  localparam int unsigned IDX_W = ahb_bus_pkg::idx_w(N_MASTERS);

  logic                          HREADY;
  logic [1:0]                    HTRANS_A;
  logic                          HWRITE_A;
  logic [N_MASTERS-1:0]          SEL;
  logic [N_MASTERS*DATA_W-1:0]   HWDATA_IN;
  logic [DATA_W-1:0]             HWDATA;
  logic                          DP_VALID;
  logic [IDX_W-1:0]              DP_MASTER;
  logic                          SEL_ERR;
  logic [CNT_W-1:0]              BEAT_CNT;

  // Bus side: drives grants and data, observes the mux.
  modport master (
    output HREADY, HTRANS_A, HWRITE_A, SEL, HWDATA_IN,
    input  HWDATA, DP_VALID, DP_MASTER, SEL_ERR, BEAT_CNT
  );

  // Mux side.
  modport slave (
    input  HREADY, HTRANS_A, HWRITE_A, SEL, HWDATA_IN,
    output HWDATA, DP_VALID, DP_MASTER, SEL_ERR, BEAT_CNT
  );

endinterface

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with an exactly-one-bit-set flag.
module onehot_enc
  import ahb_bus_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          ok
);

  // OR of set-bit indices; only meaningful when ok is high.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

  assign ok = (onehot != '0) && ((onehot & (onehot - N'(1))) == '0);

endmodule

// File: rtl/ahb_wdata_mux_n.sv
// N-master AHB write-data mux tracking the address/data pipeline.
// Define WDATA_REG_EN to register HWDATA (one cycle of added latency).
module ahb_wdata_mux_n
  import ahb_bus_pkg::*;
#(
  parameter int unsigned       N_MASTERS  = 2,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] IDLE_VALUE = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  ahb_wdata_mux_n_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(N_MASTERS);

  logic                 dp_valid_q, dp_valid_d;
  logic [IDX_W-1:0]     dp_master_q, dp_master_d;
  logic                 sel_err_q, sel_err_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic                 wr_req;
  logic                 sel_ok;
  logic [IDX_W-1:0]     sel_idx;
  logic [DATA_W-1:0]    hwdata_sel;

  assign wr_req = is_write_req(bus.HTRANS_A, bus.HWRITE_A);

  onehot_enc #(
    .N  (N_MASTERS),
    .IW (IDX_W)
  ) u_sel_enc (
    .onehot (bus.SEL),
    .idx    (sel_idx),
    .ok     (sel_ok)
  );

  // Pipeline state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dp_valid_q  <= 1'b0;
      dp_master_q <= '0;
      sel_err_q   <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      dp_valid_q  <= dp_valid_d;
      dp_master_q <= dp_master_d;
      sel_err_q   <= sel_err_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Accepted address phase opens the next data phase; wait states hold it.
  always_comb begin
    dp_valid_d  = dp_valid_q;
    dp_master_d = dp_master_q;
    sel_err_d   = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    if (bus.HREADY) begin
      dp_valid_d = wr_req & sel_ok;
      sel_err_d  = wr_req & ~sel_ok;
      if (sel_ok) dp_master_d = sel_idx;
      if (dp_valid_q) beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  // Owner's write data, or the idle value outside a data phase.
  always_comb begin
    hwdata_sel = IDLE_VALUE;
    if (dp_valid_q) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (dp_master_q == IDX_W'(i)) hwdata_sel = bus.HWDATA_IN[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef WDATA_REG_EN
  logic [DATA_W-1:0] hwdata_q;

  always_ff @(posedge CLK) begin
    if (!RST) hwdata_q <= IDLE_VALUE;
    else      hwdata_q <= hwdata_sel;
  end

  assign bus.HWDATA = hwdata_q;
`else
  assign bus.HWDATA = hwdata_sel;
`endif

  assign bus.DP_VALID  = dp_valid_q;
  assign bus.DP_MASTER = dp_master_q;
  assign bus.SEL_ERR   = sel_err_q;
  assign bus.BEAT_CNT  = beat_cnt_q;

endmodule

// File: tb/tb_ahb_wdata_mux_n.sv
// Directed-vector scoreboard bench for ahb_wdata_mux_n (2 masters, 4-bit beat counter).
module tb_ahb_wdata_mux_n;

  localparam logic [1:0] T_I = 2'b00;
  localparam logic [1:0] T_B = 2'b01;
  localparam logic [1:0] T_N = 2'b10;
  localparam logic [1:0] T_S = 2'b11;

  typedef struct {
    int          vec;
    logic        v;
    logic        m;
    logic        e;
    logic [3:0]  c;
    logic [31:0] h;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;
  logic prev_v = 1'b0;
  logic prev_m = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ahb_wdata_mux_n_if #(.N_MASTERS(2), .DATA_W(32), .CNT_W(4)) bus_if ();

  ahb_wdata_mux_n #(
    .N_MASTERS  (2),
    .DATA_W     (32),
    .IDLE_VALUE (32'h0),
    .CNT_W      (4)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus_if.slave)
  );

  task automatic check(input string name, input int vec, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0h want %0h", name, vec, act, exp);
    end
  endtask

  // Drive one vector on the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic rn, input logic hr, input logic [1:0] tr, input logic wr,
                      input logic [1:0] sel, input logic [31:0] d0, input logic [31:0] d1,
                      input logic ev, input logic em, input logic ee, input logic [3:0] ec,
                      input logic [31:0] eh);
    exp_t x;
    @(negedge clk);
    rst_n              = rn;
    bus_if.HREADY      = hr;
    bus_if.HTRANS_A    = tr;
    bus_if.HWRITE_A    = wr;
    bus_if.SEL         = sel;
    bus_if.HWDATA_IN   = {d1, d0};
`ifdef WDATA_REG_EN
    eh     = (!rn || !prev_v) ? 32'h0 : (prev_m ? d1 : d0);
    prev_v = ev;
    prev_m = em;
`endif
    x.vec = vec_no;
    x.v   = ev;
    x.m   = em;
    x.e   = ee;
    x.c   = ec;
    x.h   = eh;
    sb_q.push_back(x);
    vec_no++;
  endtask

  // Monitor: one expected record per cycle, sampled just after the rising edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb_q.size() != 0) begin
      x = sb_q.pop_front();
      check("DP_VALID",  x.vec, 32'(bus_if.DP_VALID),  32'(x.v));
      check("DP_MASTER", x.vec, 32'(bus_if.DP_MASTER), 32'(x.m));
      check("SEL_ERR",   x.vec, 32'(bus_if.SEL_ERR),   32'(x.e));
      check("BEAT_CNT",  x.vec, 32'(bus_if.BEAT_CNT),  32'(x.c));
      check("HWDATA",    x.vec, bus_if.HWDATA,         x.h);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bus_if.HREADY    = 1'b1;
    bus_if.HTRANS_A  = T_N;
    bus_if.HWRITE_A  = 1'b1;
    bus_if.SEL       = 2'b01;
    bus_if.HWDATA_IN = '0;

    // Reset with a write pending
    step(0, 1, T_N, 1, 2'b01, 32'hA5A5_0001, 32'h2222_2222, 0, 0, 0, 4'd0, 32'h0);
    step(0, 1, T_N, 1, 2'b01, 32'hA5A5_0001, 32'h2222_2222, 0, 0, 0, 4'd0, 32'h0);
    // Single M0 write then idle
    step(1, 1, T_N, 1, 2'b01, 32'hA5A5_0001, 32'h2222_2222, 1, 0, 0, 4'd0, 32'hA5A5_0001);
    step(1, 1, T_I, 0, 2'b01, 32'hA5A5_0001, 32'h2222_2222, 0, 0, 0, 4'd1, 32'h0);
    // M1 write stretched by three wait states; address inputs ignored meanwhile
    step(1, 1, T_N, 1, 2'b10, 32'h1111_1111, 32'hDEAD_BEEF, 1, 1, 0, 4'd1, 32'hDEAD_BEEF);
    step(1, 0, T_I, 0, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 1, 1, 0, 4'd1, 32'hDEAD_BEEF);
    step(1, 0, T_N, 1, 2'b11, 32'h1111_1111, 32'hDEAD_BEEF, 1, 1, 0, 4'd1, 32'hDEAD_BEEF);
    step(1, 0, T_N, 1, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 1, 1, 0, 4'd1, 32'hDEAD_BEEF);
    // Back-to-back handovers M1 -> M0 -> M1
    step(1, 1, T_N, 1, 2'b01, 32'h0000_0A0A, 32'hDEAD_BEEF, 1, 0, 0, 4'd2, 32'h0000_0A0A);
    step(1, 1, T_S, 1, 2'b10, 32'h0000_0A0A, 32'h0B0B_0B0B, 1, 1, 0, 4'd3, 32'h0B0B_0B0B);
    // Illegal grants: 11 then 00, separated by an idle
    step(1, 1, T_N, 1, 2'b11, 32'h0000_0A0A, 32'h0B0B_0B0B, 0, 1, 1, 4'd4, 32'h0);
    step(1, 1, T_I, 0, 2'b00, 32'h0000_0A0A, 32'h0B0B_0B0B, 0, 1, 0, 4'd4, 32'h0);
    step(1, 1, T_N, 1, 2'b00, 32'h0000_0A0A, 32'h0B0B_0B0B, 0, 1, 1, 4'd4, 32'h0);
    // BUSY and read are not data phases
    step(1, 1, T_B, 1, 2'b01, 32'h0000_0A0A, 32'h0B0B_0B0B, 0, 0, 0, 4'd4, 32'h0);
    step(1, 1, T_N, 0, 2'b10, 32'h0000_0A0A, 32'h0B0B_0B0B, 0, 1, 0, 4'd4, 32'h0);
    step(1, 1, T_N, 1, 2'b10, 32'h0000_0A0A, 32'hCAFE_0001, 1, 1, 0, 4'd4, 32'hCAFE_0001);
    step(1, 1, T_N, 0, 2'b01, 32'h0000_0A0A, 32'hCAFE_0001, 0, 0, 0, 4'd5, 32'h0);
    // Reset in the middle of a stretched data phase
    step(1, 1, T_N, 1, 2'b01, 32'h0000_5555, 32'hCAFE_0001, 1, 0, 0, 4'd5, 32'h0000_5555);
    step(1, 0, T_I, 0, 2'b01, 32'h0000_5555, 32'hCAFE_0001, 1, 0, 0, 4'd5, 32'h0000_5555);
    step(0, 1, T_I, 0, 2'b01, 32'h0000_5555, 32'hCAFE_0001, 0, 0, 0, 4'd0, 32'h0);
    step(1, 1, T_I, 0, 2'b01, 32'h0000_5555, 32'hCAFE_0001, 0, 0, 0, 4'd0, 32'h0);
    // 17 back-to-back beats alternating masters; the 4-bit counter wraps to 1
    for (int k = 0; k <= 16; k++) begin
      step(1, 1, T_N, 1, ((k % 2) != 0) ? 2'b10 : 2'b01,
           32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k),
           1, 1'((k % 2) != 0), 0, 4'(k % 16),
           ((k % 2) != 0) ? (32'h2000_0000 + 32'(k)) : (32'h1000_0000 + 32'(k)));
    end
    step(1, 1, T_I, 0, 2'b01, 32'h1000_0000, 32'h2000_0000, 0, 0, 0, 4'd1, 32'h0);
    step(1, 1, T_I, 0, 2'b01, 32'h1000_0000, 32'h2000_0000, 0, 0, 0, 4'd1, 32'h0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_wdata_mux_n.md
Name: ahb_wdata_mux_n

Overview:
Parametrised N-master write-data multiplexer for the shared system bus, replacing the fixed two-master write mux.
- Tracks the AHB address/data pipeline: on each accepted address phase it captures the granted master, then routes that master's write data for the full data phase, including wait states.
- Drives a deterministic idle value when there is no write data phase.
- Flags illegal grant encodings and counts completed write beats for bus monitoring.

Parameters:
N_MASTERS, 2, number of bus masters (2..16)
DATA_W, 32, write data width in bits
IDLE_VALUE, 0, value driven on HWDATA when no write data phase is active (DATA_W bits)
CNT_W, 16, width of completed-write-beat counter

Ports:
CLK  input  1  bus clock, all state updates on rising edge
RST  input  1  synchronous active-low reset; sampled on rising edge of CLK
HREADY  input  1  bus ready; 1 = current data phase completes and address phase is accepted this cycle
HTRANS_A  input  2  address-phase transfer type of the granted master
HWRITE_A  input  1  address-phase write flag of the granted master
SEL  input  N_MASTERS  one-hot address-phase grant; bit i = master i
HWDATA_IN  input  N_MASTERS*DATA_W  flattened master write data; master i occupies bits [i*DATA_W +: DATA_W]
HWDATA  output  DATA_W  write data to slaves
DP_VALID  output  1  write data phase active
DP_MASTER  output  max(1,clog2(N_MASTERS))  index of the data-phase owner
SEL_ERR  output  1  registered pulse: illegal grant seen on an accepted write address phase
BEAT_CNT  output  CNT_W  number of completed write data phases, wrapping

Behaviour:
- Reset (RST==0 at a CLK edge) dominates all other inputs. After reset: DP_VALID=0, DP_MASTER=0, SEL_ERR=0, BEAT_CNT=0, HWDATA=IDLE_VALUE.
- Define wr_req = HTRANS_A[1] & HWRITE_A, i.e. NONSEQ or SEQ write. IDLE and BUSY are never data phases.
- Define sel_ok = SEL has exactly one bit set.
- Edge with HREADY=1 (address accepted):
  - DP_VALID <= wr_req & sel_ok
  - DP_MASTER <= index(SEL) when sel_ok, otherwise hold
  - SEL_ERR <= wr_req & ~sel_ok; a write with an illegal grant is dropped and treated as idle.
- Edge with HREADY=0 (wait state): DP_VALID and DP_MASTER hold; SEL_ERR <= 0. The data phase stretches with the selected master's data unchanged.
- BEAT_CNT increments by 1 on every edge where DP_VALID=1 and HREADY=1. It wraps modulo 2^CNT_W from all-ones to 0 without saturating.
- HWDATA is combinational from registered state: DP_VALID ? HWDATA_IN[DP_MASTER] : IDLE_VALUE. It changes in the same cycle the master updates its data and is never X.
- Back-to-back transfers:
  - Consecutive accepted write address phases from different masters switch the owner on the edge where HREADY=1.
  - The old data phase completing and the new one starting coincide: the count increments and the owner changes on the same edge.
- If SEL is one-hot but wr_req=0 (read or idle), DP_VALID <= 0 and HWDATA returns to IDLE_VALUE.
- Reset asserted mid data phase abandons it. The beat is not counted, and HWDATA=IDLE_VALUE from the next cycle.

Optional Feature:
Macro WDATA_REG_EN.
- Defined: HWDATA is registered. Each edge, HWDATA <= (DP_VALID ? HWDATA_IN[DP_MASTER] : IDLE_VALUE) using pre-edge register values; reset loads IDLE_VALUE. Data reaches slaves one cycle late, for slaves that sample in the following cycle.
- Undefined: HWDATA is combinational as above, with zero added latency.
- DP_VALID, DP_MASTER, SEL_ERR and BEAT_CNT are identical in both builds.

Decomposition:
- Shared package ahb_bus_pkg:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11
  - clog2-based index-width function
- One sub-module, onehot_enc: N-bit one-hot to binary index plus onehot_ok flag (exactly one bit set). It is reusable by the read mux and the arbiter.

Test Plan:
1. Reset: hold RST=0 for 2 cycles with SEL=2'b01 and writes pending -> HWDATA=0, DP_VALID=0, BEAT_CNT=0.
2. Single write: HREADY=1, SEL=01, HTRANS_A=NONSEQ, HWRITE_A=1, then HWDATA_IN[0]=32'hA5A5_0001 -> DP_VALID=1, DP_MASTER=0, HWDATA=32'hA5A5_0001, BEAT_CNT=1 after the completing edge.
3. Wait states: master 1 write followed by 3 cycles of HREADY=0 -> HWDATA tracks HWDATA_IN[1]=32'hDEAD_BEEF for all 3 cycles, BEAT_CNT unchanged until HREADY=1.
4. Handover: back-to-back writes M0 then M1 -> owner switches on the edge where HREADY=1, with no idle cycle; BEAT_CNT +1 per beat.
5. Illegal grant: SEL=2'b11 or 2'b00 with a NONSEQ write, HREADY=1 -> SEL_ERR=1 for exactly 1 cycle, DP_VALID=0, HWDATA=IDLE_VALUE.
6. Wrap: CNT_W=4 with 17 completed beats -> BEAT_CNT=1. Repeat with WDATA_REG_EN defined -> HWDATA lags by exactly 1 cycle.
